// File: rtl/fp_rsqrte_nr_if.sv
// Operand/result handshake bundle for the reciprocal-square-root unit.
// Flag signals exist only when FRSQRTE_FLAGS_EN is defined.
interface fp_rsqrte_nr_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] o;
`ifdef FRSQRTE_FLAGS_EN
   logic        inv_flag;
   logic        dz_flag;
`endif

   modport slave (
      input  in_valid, a, out_ready,
`ifdef FRSQRTE_FLAGS_EN
      output inv_flag, dz_flag,
`endif
      output in_ready, out_valid, o
   );

   modport master (
      output in_valid, a, out_ready,
`ifdef FRSQRTE_FLAGS_EN
      input  inv_flag, dz_flag,
`endif
      input  in_ready, out_valid, o
   );
endinterface

// File: rtl/fp_rsqrte_nr.sv
// Binary32 1/sqrt(a): magic-constant seed refined by NR_ITER Newton-Raphson steps on one
// shared adder and two shared truncating multipliers. Optional flags: FRSQRTE_FLAGS_EN.
module fp_rsqrte_nr #(
   parameter int NR_ITER = 1,
   parameter int MUL_LAT = 4,
   parameter int ADD_LAT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   fp_rsqrte_nr_if.slave    bus
);

   typedef enum logic [2:0] {IDLE, MULP5, MULYY, MULX2YY, SUB, MULY, DONE} state_t;

   localparam logic [31:0] MAGIC     = 32'h5F3759DF;
   localparam logic [31:0] HALF      = 32'h3F000000;
   localparam logic [31:0] THREEHALF = 32'h3FC00000;

   // Truncating multiply; denormal operands/results flush to zero.
   function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
      logic               sgn;
      logic [47:0]        prod;
      logic [22:0]        frac;
      logic signed [10:0] e;
      sgn = x[31] ^ y[31];
      if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {sgn, 31'd0};
      prod = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
      e = $signed({3'b000, x[30:23]}) + $signed({3'b000, y[30:23]}) - 11'sd127;
      if (prod[47]) begin
         frac = prod[46:24];
         e    = e + 11'sd1;
      end else begin
         frac = prod[45:23];
      end
      if (e <= 11'sd0)   return {sgn, 31'd0};
      if (e >= 11'sd255) return {sgn, 8'hFF, 23'd0};
      return {sgn, e[7:0], frac};
   endfunction

   // Truncating add; aligned operand keeps 26 extra bits plus a sticky LSB so the
   // chopped result equals the exact sum truncated toward zero.
   function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
      logic [31:0]       big, sml;
      logic [7:0]        d;
      logic [49:0]       mb, ms, mfull;
      logic [50:0]       sum, nrm;
      logic [22:0]       frac;
      logic signed [9:0] e;
      int                lead;
      if (y[30:23] == 8'd0) return (x[30:23] == 8'd0) ? 32'd0 : x;
      if (x[30:23] == 8'd0) return y;
      if (x[30:0] >= y[30:0]) begin
         big = x;
         sml = y;
      end else begin
         big = y;
         sml = x;
      end
      d     = big[30:23] - sml[30:23];
      mb    = {1'b1, big[22:0], 26'd0};
      mfull = {1'b1, sml[22:0], 26'd0};
      if (d >= 8'd50) begin
         ms = 50'd1;
      end else begin
         ms = mfull >> d;
         if ((ms << d) != mfull) ms[0] = 1'b1;
      end
      if (big[31] == sml[31]) sum = {1'b0, mb} + {1'b0, ms};
      else                    sum = {1'b0, mb} - {1'b0, ms};
      if (sum == 51'd0) return 32'd0;
      e = $signed({2'b00, big[30:23]});
      if (sum[50]) begin
         frac = sum[49:27];
         e    = e + 10'sd1;
      end else begin
         lead = 0;
         for (int i = 0; i < 50; i++) if (sum[i]) lead = i;
         nrm  = sum << (49 - lead);
         frac = nrm[48:26];
         e    = e - 10'(49 - lead);
      end
      if (e <= 10'sd0)   return 32'd0;
      if (e >= 10'sd255) return {big[31], 8'hFF, 23'd0};
      return {big[31], e[7:0], frac};
   endfunction

   state_t      state, state_n;
   logic [7:0]  cnt, cnt_n;
   logic [2:0]  iter, iter_n;
   logic [31:0] o_r;
   logic [31:0] a_r, y, x2, yy, p, t;
   logic [31:0] m0a, m0b, m0, m1, add_r;
   logic [31:0] seed, spec_res;
   logic        accept, last, special;
   logic        a_zero, a_expmax, a_nan;

   assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
   assign bus.out_valid = (state == DONE);
   assign bus.o         = o_r;
   assign accept        = bus.in_valid & bus.in_ready & ce;
   assign last          = (cnt == 8'd1);

   assign a_zero   = (bus.a[30:23] == 8'd0);
   assign a_expmax = (bus.a[30:23] == 8'hFF);
   assign a_nan    = a_expmax & (|bus.a[22:0]);
   assign special  = a_zero | a_expmax | bus.a[31];
   assign seed     = MAGIC - {1'b0, bus.a[31:1]};

   always_comb begin
      spec_res = 32'd0;
      if (a_zero)         spec_res = 32'h7F800000;
      else if (a_nan)     spec_res = bus.a | 32'h00400000;
      else if (bus.a[31]) spec_res = 32'h7FC00000;
   end

   always_comb begin
      m0a = y;
      m0b = t;
      case (state)
         MULP5: begin
            m0a = a_r;
            m0b = HALF;
         end
         MULX2YY: begin
            m0a = x2;
            m0b = yy;
         end
         default: ;
      endcase
   end

   assign m0    = fmul(m0a, m0b);
   assign m1    = fmul(y, y);
   assign add_r = fadd(THREEHALF, {~p[31], p[30:0]});

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      iter_n  = iter;
      if (ce) begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  if (special || NR_ITER == 0) begin
                     state_n = DONE;
                  end else begin
                     state_n = MULP5;
                     cnt_n   = 8'(MUL_LAT);
                     iter_n  = 3'(NR_ITER);
                  end
               end else if (state == DONE && bus.out_ready) begin
                  state_n = IDLE;
               end
            end
            MULP5, MULYY: begin
               if (last) begin
                  state_n = MULX2YY;
                  cnt_n   = 8'(MUL_LAT);
               end else cnt_n = cnt - 8'd1;
            end
            MULX2YY: begin
               if (last) begin
                  state_n = SUB;
                  cnt_n   = 8'(ADD_LAT);
               end else cnt_n = cnt - 8'd1;
            end
            SUB: begin
               if (last) begin
                  state_n = MULY;
                  cnt_n   = 8'(MUL_LAT);
               end else cnt_n = cnt - 8'd1;
            end
            MULY: begin
               if (last) begin
                  iter_n = iter - 3'd1;
                  if (iter == 3'd1) begin
                     state_n = DONE;
                     cnt_n   = 8'd0;
                  end else begin
                     state_n = MULYY;
                     cnt_n   = 8'(MUL_LAT);
                  end
               end else cnt_n = cnt - 8'd1;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 8'd0;
         iter  <= 3'd0;
         o_r   <= 32'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         iter  <= iter_n;
         if (accept) begin
            if (special)           o_r <= spec_res;
            else if (NR_ITER == 0) o_r <= seed;
         end else if (ce && state == MULY && last && iter == 3'd1) begin
            o_r <= m0;
         end
      end
   end

   // Working registers carry no reset; they are always reloaded on accept.
   always_ff @(posedge clk) begin
      if (ce) begin
         if (accept) begin
            a_r <= bus.a;
            y   <= seed;
         end
         if (last) begin
            case (state)
               MULP5: begin
                  x2 <= m0;
                  yy <= m1;
               end
               MULYY:   yy <= m1;
               MULX2YY: p  <= m0;
               SUB:     t  <= add_r;
               MULY:    y  <= m0;
               default: ;
            endcase
         end
      end
   end

`ifdef FRSQRTE_FLAGS_EN
   logic inv_r, dz_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inv_r <= 1'b0;
         dz_r  <= 1'b0;
      end else if (accept) begin
         inv_r <= (bus.a[31] & ~a_zero & ~a_nan) | (a_nan & ~bus.a[22]);
         dz_r  <= a_zero;
      end
   end

   assign bus.inv_flag = inv_r;
   assign bus.dz_flag  = dz_r;
`endif

endmodule

// File: tb/tb_fp_rsqrte_nr.sv
// Randomized self-checking bench for fp_rsqrte_nr against a real-arithmetic reference model.
module tb_fp_rsqrte_nr;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic ce    = 1'b1;

   always #5 clk = ~clk;

   fp_rsqrte_nr_if bus ();
   fp_rsqrte_nr_if bus2 ();
   fp_rsqrte_nr_if bus0 ();

   fp_rsqrte_nr #(.NR_ITER(1), .MUL_LAT(4), .ADD_LAT(4)) dut (.clk(clk), .rst_n(rst_n), .ce(ce), .bus(bus));
   fp_rsqrte_nr #(.NR_ITER(2), .MUL_LAT(4), .ADD_LAT(4)) u2  (.clk(clk), .rst_n(rst_n), .ce(ce), .bus(bus2));
   fp_rsqrte_nr #(.NR_ITER(0), .MUL_LAT(4), .ADD_LAT(4)) u0  (.clk(clk), .rst_n(rst_n), .ce(ce), .bus(bus0));

   int n_tests = 0;
   int n_fail  = 0;
   logic inv_seen, dz_seen;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic real f2r(input logic [31:0] f);
      logic [10:0] e;
      if (f[30:23] == 8'd0) return 0.0;
      e = {3'b000, f[30:23]} + 11'd896;
      return $bitstoreal({f[31], e, f[22:0], 29'd0});
   endfunction

   // Chop an exact double to binary32 toward zero; tiny results flush, huge ones go to inf.
   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      int          e;
      d = $realtobits(r);
      e = int'(d[62:52]) - 896;
      if (e <= 0)   return {d[63], 31'd0};
      if (e >= 255) return {d[63], 8'hFF, 23'd0};
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic logic [31:0] ref_rsqrt(input logic [31:0] a, input int n);
      logic [31:0] y, x2, yy, p, t;
      if (a[30:23] == 8'd0)                       return 32'h7F800000;
      if (a[30:23] == 8'hFF && a[22:0] != 23'd0)  return a | 32'h00400000;
      if (a == 32'h7F800000)                      return 32'h00000000;
      if (a[31])                                  return 32'h7FC00000;
      y  = 32'h5F3759DF - (a >> 1);
      x2 = r2f(f2r(a) * 0.5);
      for (int k = 0; k < n; k++) begin
         yy = r2f(f2r(y) * f2r(y));
         p  = r2f(f2r(x2) * f2r(yy));
         t  = r2f(1.5 - f2r(p));
         y  = r2f(f2r(y) * f2r(t));
      end
      return y;
   endfunction

   function automatic logic [31:0] rand_normal();
      return {1'b0, 8'($urandom_range(40, 210)), 23'($urandom)};
   endfunction

   task automatic run_op(input logic [31:0] av, input int freeze_at,
                         output logic [31:0] res, output int lat);
      int guard = 0;
      while (!bus.in_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      bus.a = av;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 200) begin
         ce = (freeze_at > 0 && lat >= freeze_at && lat < freeze_at + 5) ? 1'b0 : 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      ce = 1'b1;
      res = bus.o;
`ifdef FRSQRTE_FLAGS_EN
      inv_seen = bus.inv_flag;
      dz_seen  = bus.dz_flag;
`else
      inv_seen = 1'b0;
      dz_seen  = 1'b0;
`endif
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] res, av, av2, held;
      logic [31:0] specials [9];
      int          lat, seen;
      real         r;

      specials = '{32'h00000000, 32'h7F800000, 32'hC0000000, 32'h7F800001, 32'h80000000,
                   32'h00000123, 32'hFF800000, 32'hFFC00001, 32'h7FC00000};
      bus.in_valid = 0;  bus.a = 0;  bus.out_ready = 0;
      bus2.in_valid = 0; bus2.a = 0; bus2.out_ready = 0;
      bus0.in_valid = 0; bus0.a = 0; bus0.out_ready = 0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_o", bus.o, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // 4.0 -> ~0.5
      run_op(32'h40800000, 0, res, lat);
      chk("t1_lat", 32'(lat), 32'd17);
      chk("t1_o", res, ref_rsqrt(32'h40800000, 1));
      r = f2r(res);
      chk("t1_within_0p2pct", 32'(r > 0.499 && r < 0.501), 32'd1);

      foreach (specials[i]) begin
         run_op(specials[i], 0, res, lat);
         chk("spec_lat", 32'(lat), 32'd1);
         chk("spec_o", res, ref_rsqrt(specials[i], 1));
`ifdef FRSQRTE_FLAGS_EN
         chk("spec_dz", 32'(dz_seen), 32'(specials[i][30:23] == 8'd0));
         chk("spec_inv", 32'(inv_seen),
             32'((specials[i][31] && specials[i][30:23] != 8'd0 && specials[i][30:0] <= 32'h7F800000)
                 || (specials[i][30:0] > 32'h7F800000 && !specials[i][22])));
`endif
      end

      repeat (25) begin
         av = rand_normal();
         run_op(av, 0, res, lat);
         chk("rand_lat", 32'(lat), 32'd17);
         chk("rand_o", res, ref_rsqrt(av, 1));
         chk("rand_flags", {30'd0, inv_seen, dz_seen}, 32'd0);
      end

      // Backpressure, then take result and accept next operand on the same edge
      av = rand_normal();
      bus.a = av; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("bp_lat", 32'(lat), 32'd17);
      held = bus.o;
      chk("bp_o", held, ref_rsqrt(av, 1));
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         chk("bp_stable", bus.o, held);
         chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
         chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      end
      av2 = rand_normal();
      bus.a = av2; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      #1;
      chk("bp_in_ready_b2b", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("bp_taken", 32'(bus.out_valid), 32'd0);
      chk("bp_accepted", 32'(bus.in_ready), 32'd0);
      lat = 1;
      while (!bus.out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("bp2_lat", 32'(lat), 32'd17);
      chk("bp2_o", bus.o, ref_rsqrt(av2, 1));
      @(posedge clk); #1;

      // ce low for 5 cycles while in SUB
      av = rand_normal();
      run_op(av, 10, res, lat);
      chk("ce_lat", 32'(lat), 32'd22);
      chk("ce_o", res, ref_rsqrt(av, 1));

      // Reset while in MULX2YY
      av = rand_normal();
      bus.a = av; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen++;
      end
      chk("rst_no_stale", 32'(seen), 32'd0);
      av = rand_normal();
      run_op(av, 0, res, lat);
      chk("rst_next_lat", 32'(lat), 32'd17);
      chk("rst_next_o", res, ref_rsqrt(av, 1));

      // NR_ITER=0: raw seed one cycle after accept
      bus0.a = 32'h3F800000; bus0.in_valid = 1'b1; bus0.out_ready = 1'b1;
      @(posedge clk); #1;
      bus0.in_valid = 1'b0;
      chk("nr0_valid", 32'(bus0.out_valid), 32'd1);
      chk("nr0_o", bus0.o, ref_rsqrt(32'h3F800000, 0));
      @(posedge clk); #1;

      // NR_ITER=2 on 1.0
      bus2.a = 32'h3F800000; bus2.in_valid = 1'b1; bus2.out_ready = 1'b1;
      @(posedge clk); #1;
      bus2.in_valid = 1'b0;
      lat = 1;
      while (!bus2.out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("nr2_lat", 32'(lat), 32'd33);
      chk("nr2_o", bus2.o, ref_rsqrt(32'h3F800000, 2));
      r = f2r(bus2.o);
      chk("nr2_close", 32'(r > 1.0 - 1.0e-5 && r < 1.0 + 1.0e-5), 32'd1);
      @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
